// File: rtl/ddr_pair_deser.sv
// ddr_pair_deser: dual-edge serial receiver. Samples din on both clock
// edges, pairs each rising-edge bit with the following falling-edge bit,
// assembles pairs MSB-first into W-bit words and queues them in a small
// first-word-fall-through FIFO with a valid/ready output.
module ddr_pair_deser #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_en,
  input  logic         sof,
  output logic [W-1:0] word_data,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         overflow,
  output logic         align_err
);

  localparam int HALF = W / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {S_HUNT, S_ASSEMBLE} state_t;

  // Capture registers
  logic         r_a_q;
  logic         r_en_q;
  logic         r_sof_q;
  logic         r_b_q;

  // Assembler state
  state_t       r_state;
  logic [CW-1:0] r_cnt;
  logic [W-3:0] r_shreg;

  // FIFO state
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]  r_count;
  logic         r_overflow;
  logic         r_align_err;

  logic [1:0]   w_pair;
  logic [W-1:0] w_word;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_push_ok;

  // The pair is only meaningful when r_en_q is set; b has no reset.
  assign w_pair = {r_a_q, r_b_q};
  // The word as it would look if this pair completes it.
  assign w_word = {r_shreg, w_pair};

  // A normal (non-sof) pair that brings the count to W/2 completes a word.
  // A sof pair can never complete one since W/2 >= 2.
  assign w_push = r_en_q && (r_state == S_ASSEMBLE) && !r_sof_q && (r_cnt == LAST_CNT);

  assign word_valid = (r_count != '0);
  assign w_pop      = word_valid && word_ready;
  assign w_full     = (r_count == FULL_CNT);
  // When full, a push only fits if the head leaves on the same edge.
  assign w_push_ok  = w_push && (!w_full || w_pop);

  assign word_data  = word_valid ? r_mem[r_rd_ptr] : '0;
  assign overflow   = r_overflow;
  assign align_err  = r_align_err;

  // Rising-edge capture of bit A and its qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_q   <= 1'b0;
      r_en_q  <= 1'b0;
      r_sof_q <= 1'b0;
    end else begin
      r_a_q   <= din;
      r_en_q  <= din_en;
      r_sof_q <= sof;
    end
  end

  // Falling-edge capture of bit B; consumed only when r_en_q is set.
  always_ff @(negedge clk) begin
    r_b_q <= din;
  end

  // Assembler FSM: hunt for sof, then shift pairs in and count them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_align_err <= 1'b0;
    end else if (r_en_q) begin
      case (r_state)
        S_HUNT: begin
          if (r_sof_q) begin
            r_shreg      <= '0;
            r_shreg[1:0] <= w_pair;
            r_cnt        <= CW'(1);
            r_state      <= S_ASSEMBLE;
          end
        end
        S_ASSEMBLE: begin
          if (r_sof_q) begin
            // A sof in the middle of a word throws the partial away.
            if (r_cnt != '0) begin
              r_align_err <= 1'b1;
            end
            r_shreg      <= '0;
            r_shreg[1:0] <= w_pair;
            r_cnt        <= CW'(1);
          end else if (r_cnt == LAST_CNT) begin
            r_shreg <= w_word[W-3:0];
            r_cnt   <= '0;
          end else begin
            r_shreg <= w_word[W-3:0];
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_HUNT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // FIFO storage write (no reset so it can map onto distributed RAM).
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
